// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and width defaults for the LC-3 memory arbiter
package lc3_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // 0 = CPU, 1 = bench/loader
    typedef logic port_id_t;

endpackage

// File: rtl/lc3_rr_pick.sv
// rtl/lc3_rr_pick.sv - two-way round-robin winner select (combinational)
module lc3_rr_pick
    import lc3_mem_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output port_id_t   grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        // On a tie the port not granted last wins; otherwise the lone requester wins.
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - arbitrates CPU and loader access to LC-3 memory
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_mar,
    output logic [DATA_W-1:0] mem_mdr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    state_e            state_q, state_d;
    port_id_t          last_grant_q, last_grant_d;
    port_id_t          port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    port_id_t pick_grant;
    logic     pick_valid;

    lc3_rr_pick u_pick (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        mar_d        = mar_q;
        mdr_d        = mdr_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                // MAR/MDR only change on the IDLE->ACCESS edge, so memory sees a stable address.
                if (pick_valid) begin
                    state_d      = ACCESS;
                    port_d       = pick_grant;
                    last_grant_d = pick_grant;
                    we_d         = pick_grant ? we1    : we0;
                    mar_d        = pick_grant ? addr1  : addr0;
                    mdr_d        = pick_grant ? wdata1 : wdata0;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if (!we_q) begin
                    if (port_q) rdata1_d = mem_out;
                    else        rdata0_d = mem_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            mar_q        <= '0;
            mdr_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Decoded from state so an asynchronous reset drops write enable and acks at once.
    assign busy    = (state_q != IDLE);
    assign mem_we  = (state_q == ACCESS) && we_q;
    assign ack0    = (state_q == RESP) && (port_q == 1'b0);
    assign ack1    = (state_q == RESP) && (port_q == 1'b1);
    assign mem_mar = mar_q;
    assign mem_mdr = mdr_q;
    // Read data is forwarded during the ack cycle and held in the register afterwards.
    assign rdata0  = (ack0 && !we_q) ? mem_out : rdata0_q;
    assign rdata1  = (ack1 && !we_q) ? mem_out : rdata1_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - directed self-checking bench for lc3_mem_arbiter
module tb_lc3_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        we0, we1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] mem_mar, mem_mdr;
    logic        mem_we;
    logic [15:0] mem_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:255];

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .we0     (we0),
        .we1     (we1),
        .ack0    (ack0),
        .ack1    (ack1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .mem_mar (mem_mar),
        .mem_mdr (mem_mdr),
        .mem_we  (mem_we),
        .mem_out (mem_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_mar[7:0]] <= mem_mdr;
        mem_out <= mem[mem_mar[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("inv_ack_excl", {31'd0, ack0 && ack1}, 32'd0);
            check("inv_we_busy", {31'd0, mem_we && !busy}, 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        mem_out = 16'h0000;
        reset = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_mar", {16'd0, mem_mar}, 32'd0);
        check("rst_mdr", {16'd0, mem_mdr}, 32'd0);
        check("rst_rdata", {rdata1, rdata0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single write from port 1
        req1 = 1; addr1 = 16'h3000; wdata1 = 16'hBEEF; we1 = 1;
        tick;
        check("wr_busy", {31'd0, busy}, 32'd1);
        check("wr_we", {31'd0, mem_we}, 32'd1);
        check("wr_mar", {16'd0, mem_mar}, 32'h3000);
        check("wr_mdr", {16'd0, mem_mdr}, 32'hBEEF);
        check("wr_ack_early", {30'd0, ack1, ack0}, 32'd0);
        tick;
        check("wr_ack", {30'd0, ack1, ack0}, 32'b10);
        check("wr_we_resp", {31'd0, mem_we}, 32'd0);
        check("wr_mar_hold", {16'd0, mem_mar}, 32'h3000);
        req1 = 0; we1 = 0;
        tick;
        check("wr_idle", {29'd0, busy, ack1, ack0}, 32'd0);
        check("wr_we_idle", {31'd0, mem_we}, 32'd0);

        // Read-back from port 0
        req0 = 1; addr0 = 16'h3000; we0 = 0;
        tick;
        check("rd_we_acc", {31'd0, mem_we}, 32'd0);
        check("rd_mar", {16'd0, mem_mar}, 32'h3000);
        tick;
        check("rd_ack", {30'd0, ack1, ack0}, 32'b01);
        check("rd_data", {16'd0, rdata0}, 32'hBEEF);
        check("rd_we_resp", {31'd0, mem_we}, 32'd0);
        req0 = 0;
        tick;
        check("rd_hold", {16'd0, rdata0}, 32'hBEEF);
        check("rd_ack_gone", {30'd0, ack1, ack0}, 32'd0);

        // Reset pulse so the tie starts from last_grant = 1
        #2 reset = 1'b0;
        #1;
        check("rst2_rdata", {rdata1, rdata0}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Tie fairness: acks expected after ticks 2,5,8,11 alternating 0,1,0,1
        req0 = 1; addr0 = 16'h3000; we0 = 0;
        req1 = 1; addr1 = 16'h3001; we1 = 0;
        for (int i = 1; i <= 11; i++) begin
            tick;
            check($sformatf("tie_ack0_t%0d", i), {31'd0, ack0},
                  {31'd0, (i % 3 == 2) && ((i / 3) % 2 == 0)});
            check($sformatf("tie_ack1_t%0d", i), {31'd0, ack1},
                  {31'd0, (i % 3 == 2) && ((i / 3) % 2 == 1)});
            if (ack0) check("tie_rdata0", {16'd0, rdata0}, 32'hBEEF);
            if (ack1) check("tie_rdata1", {16'd0, rdata1}, 32'hA5A4);
        end
        req0 = 0; req1 = 0;
        tick;
        tick;
        check("tie_idle", {31'd0, busy}, 32'd0);

        // Drop after grant: lone port 1 wins even though it was granted last
        req1 = 1; addr1 = 16'h3002; we1 = 0;
        tick;
        check("drop_busy", {31'd0, busy}, 32'd1);
        req1 = 0;
        tick;
        check("drop_ack", {30'd0, ack1, ack0}, 32'b10);
        check("drop_rdata", {16'd0, rdata1}, 32'hA5A7);
        tick;
        check("drop_idle1", {31'd0, busy}, 32'd0);
        tick;
        check("drop_idle2", {30'd0, busy, mem_we}, 32'd0);

        // Reset during the ACCESS of a write
        req1 = 1; addr1 = 16'h3010; wdata1 = 16'h1234; we1 = 1;
        tick;
        check("rma_we", {31'd0, mem_we}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rma_we_drop", {31'd0, mem_we}, 32'd0);
        check("rma_busy", {31'd0, busy}, 32'd0);
        check("rma_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rma_mar", {16'd0, mem_mar}, 32'd0);
        req1 = 0; we1 = 0;
        tick;
        check("rma_ack_rst", {30'd0, ack1, ack0}, 32'd0);
        reset = 1'b1;
        req0 = 1; addr0 = 16'h3010; we0 = 0;
        tick;
        check("rma_rd_mar", {16'd0, mem_mar}, 32'h3010);
        tick;
        check("rma_rd_ack", {30'd0, ack1, ack0}, 32'b01);
        check("rma_rd_data", {16'd0, rdata0}, 32'hA5B5);
        req0 = 0;
        tick;
        check("end_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req0 / req1, input, 1 each, access request; port 0 is the CPU and port 1 is the bench/loader.
REQ-006 SHALL have port addr0 / addr1, input, ADDR_W, request address.
REQ-007 SHALL have port wdata0 / wdata1, input, DATA_W, write data.
REQ-008 SHALL have port we0 / we1, input, 1, 1 = write and 0 = read.
REQ-009 SHALL have port ack0 / ack1, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rdata0 / rdata1, output, DATA_W, read data, valid while ackN is high.
REQ-011 SHALL have port mem_mar, output, ADDR_W, address to memory MARReg.
REQ-012 SHALL have port mem_mdr, output, DATA_W, write data to memory mdrOut.
REQ-013 SHALL have port mem_we, output, 1, memory write enable (memWE).
REQ-014 SHALL have port mem_out, input, DATA_W, memory read data; valid one cycle after mem_mar is presented.
REQ-015 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-017 In IDLE with any reqN high, SHALL latch the winner's addr, wdata, we and port id, then go to ACCESS.
REQ-018 In ACCESS, SHALL drive mem_mar and mem_mdr from the latched values and assert mem_we = latched we for exactly this one cycle, then go to RESP.
REQ-019 In RESP, SHALL pulse ackN for the latched port for one cycle, load rdataN from mem_out on reads (on writes rdataN holds its previous value), then go to IDLE.
REQ-020 Latency: a request sampled in cycle N SHALL produce ACCESS in N+1 and ack in N+2; the maximum throughput is one access per 3 cycles.
REQ-021 Arbitration SHALL be round-robin: on simultaneous req0 and req1, the port not granted last wins; last_grant resets to 1, so port 0 wins the first tie.
REQ-022 A single requester SHALL be granted regardless of last_grant.
REQ-023 Requesters SHALL hold reqN and their inputs until ackN; the arbiter samples inputs only in IDLE.
REQ-024 reqN dropped after grant SHALL NOT abort the access; the access completes and ackN still pulses.
REQ-025 reqN still high in the cycle after ackN SHALL be treated as a new request.
REQ-026 mem_we SHALL be 0 in every state except ACCESS with a latched write; the arbiter never issues a write in IDLE or RESP.
REQ-027 mem_mar and mem_mdr SHALL hold their last values outside ACCESS, so the memory sees no spurious address changes.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-029 On reset low, SHALL asynchronously force state = IDLE, mem_we = 0, ack0 = ack1 = 0, busy = 0, mem_mar = 0, mem_mdr = 0, rdata0 = rdata1 = 0, last_grant = 1.
REQ-030 Reset asserted during ACCESS or RESP SHALL abort the transaction with no ack; the requester must re-request after reset releases.
REQ-031 The first grant after reset release SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-032 Package lc3_mem_pkg SHALL hold the state enum (IDLE, ACCESS, RESP), the port-id type and the default width constants.
REQ-033 The round-robin winner selection SHALL be a combinational sub-module lc3_rr_pick (inputs req[1:0] and last_grant; outputs grant and valid).
REQ-034 The block SHALL sit between ammon_lc3/test_if and memory in lc3_top, replacing the direct connection of mar, mdr and memwe.

Verification
REQ-035 Single write: req1, addr1 = 16'h3000, wdata1 = 16'hBEEF, we1 = 1 -> mem_we high for exactly one cycle with mar = 3000 and mdr = BEEF, and ack1 two cycles after the request is sampled.
REQ-036 Read-back: req0, addr0 = 16'h3000, we0 = 0 after REQ-035 -> ack0 at N+2 with rdata0 = 16'hBEEF, and mem_we stays 0 throughout.
REQ-037 Tie fairness: req0 and req1 held high continuously for 12 cycles -> grants alternate 0,1,0,1 (four acks), port 0 first after reset.
REQ-038 Drop after grant: req1 deasserted during ACCESS -> ack1 still pulses in RESP and no second access occurs.
REQ-039 Reset mid-access: reset driven low during ACCESS of a write -> mem_we falls immediately, no ack, busy = 0, and a post-reset read of that address is then issued.
REQ-040 Assertions: ack0 and ack1 are never both high; mem_we implies state == ACCESS; busy equals (state != IDLE).
